// File: rtl/ctrl_fetch_queue.sv
// rtl/ctrl_fetch_queue.sv - instruction fetch stage with first-word-fall-through queue
//
// Issues instruction-memory reads from the current PC, captures the
// synchronous-read data one cycle later and buffers {pc, instruction}
// pairs for decode. A taken branch in EX flushes queued and in-flight work.
//
// Optional feature macro: FETCH_BYPASS_EN
//   When defined, an empty queue forwards the returning read data straight
//   to the decode outputs (one cycle earlier). Otherwise the queue always
//   sits between the memory and decode.
//
// Ports:
//   clk              core clock
//   reset            asynchronous active-high reset
//   prog_ctr         current PC
//   branch_taken_EX  taken branch from EX, flushes the queue
//   imem_addr        instruction memory read address (= prog_ctr)
//   imem_rd_en       instruction memory read enable
//   imem_rdata       read data, valid one cycle after an enabled read
//   fetch_stall      hold request to the program counter
//   ready_ID         decode accepts the head entry
//   instr_vld_ID     head entry valid
//   instr_ID         head instruction
//   pc_ID            PC of the head instruction
module ctrl_fetch_queue #(
  parameter int PROG_CTR_WID = 10,
  parameter int INSTR_WID    = 16,
  parameter int IQ_DEPTH     = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [PROG_CTR_WID-1:0] prog_ctr,
  input  logic                    branch_taken_EX,
  output logic [PROG_CTR_WID-1:0] imem_addr,
  output logic                    imem_rd_en,
  input  logic [INSTR_WID-1:0]    imem_rdata,
  output logic                    fetch_stall,
  input  logic                    ready_ID,
  output logic                    instr_vld_ID,
  output logic [INSTR_WID-1:0]    instr_ID,
  output logic [PROG_CTR_WID-1:0] pc_ID
);

  localparam int PW = $clog2(IQ_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [CW-1:0]           count;
  logic                    req_vld_q;
  logic [PROG_CTR_WID-1:0] req_pc_q;

  logic [INSTR_WID-1:0]    instr_mem [IQ_DEPTH];
  logic [PROG_CTR_WID-1:0] pc_mem    [IQ_DEPTH];

  logic q_empty;
  logic pop_q;
  logic push_q;
  logic byp_vld;
  logic byp_take;

  assign q_empty = (count == '0);

  // Stall one entry early so the read already in flight always has a slot.
  assign fetch_stall = (count >= CW'(IQ_DEPTH - 1));
  assign imem_addr   = prog_ctr;
  assign imem_rd_en  = !reset && !fetch_stall && !branch_taken_EX;

`ifdef FETCH_BYPASS_EN
  // Returning data goes straight to decode when nothing is queued ahead of it.
  assign byp_vld  = q_empty && req_vld_q && !branch_taken_EX;
  assign byp_take = byp_vld && ready_ID;

  always_comb begin
    instr_vld_ID = 1'b0;
    instr_ID     = '0;
    pc_ID        = '0;
    if (!q_empty) begin
      instr_vld_ID = 1'b1;
      instr_ID     = instr_mem[rd_ptr];
      pc_ID        = pc_mem[rd_ptr];
    end else if (byp_vld) begin
      instr_vld_ID = 1'b1;
      instr_ID     = imem_rdata;
      pc_ID        = req_pc_q;
    end
  end
`else
  assign byp_vld  = 1'b0;
  assign byp_take = 1'b0;

  always_comb begin
    instr_vld_ID = 1'b0;
    instr_ID     = '0;
    pc_ID        = '0;
    if (!q_empty) begin
      instr_vld_ID = 1'b1;
      instr_ID     = instr_mem[rd_ptr];
      pc_ID        = pc_mem[rd_ptr];
    end
  end
`endif

  // A bypassed word that decode takes this cycle never enters the queue.
  assign pop_q  = !q_empty && ready_ID;
  assign push_q = req_vld_q && !branch_taken_EX && !byp_take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      req_vld_q <= 1'b0;
      req_pc_q  <= '0;
    end else begin
      req_pc_q <= prog_ctr;
      if (branch_taken_EX) begin
        // Flush wins over any push or pop this cycle.
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        count     <= '0;
        req_vld_q <= 1'b0;
      end else begin
        req_vld_q <= imem_rd_en;
        if (push_q) wr_ptr <= wr_ptr + 1'b1;
        if (pop_q)  rd_ptr <= rd_ptr + 1'b1;
        case ({push_q, pop_q})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (push_q) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= req_pc_q;
    end
  end

`ifndef SYNTHESIS
  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push_q && !pop_q && count == CW'(IQ_DEPTH)))
    else $error("push into full fetch queue");
`endif

endmodule

// File: tb/tb_ctrl_fetch_queue.sv
// tb/tb_ctrl_fetch_queue.sv - self-checking bench for ctrl_fetch_queue
module tb_ctrl_fetch_queue;

`ifdef FETCH_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  prog_ctr;
  logic        branch_taken_EX;
  logic [9:0]  imem_addr;
  logic        imem_rd_en;
  logic [15:0] imem_rdata = 16'h0;
  logic        fetch_stall;
  logic        ready_ID;
  logic        instr_vld_ID;
  logic [15:0] instr_ID;
  logic [9:0]  pc_ID;

  int total = 0;
  int bad   = 0;

  ctrl_fetch_queue #(.PROG_CTR_WID(10), .INSTR_WID(16), .IQ_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .branch_taken_EX(branch_taken_EX),
    .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
    .fetch_stall(fetch_stall), .ready_ID(ready_ID), .instr_vld_ID(instr_vld_ID),
    .instr_ID(instr_ID), .pc_ID(pc_ID)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mdata(input logic [9:0] a);
    return 16'h1000 + {6'b0, a};
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) if (imem_rd_en) imem_rdata <= mdata(imem_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] p, input logic r, input logic b);
    prog_ctr = p; ready_ID = r; branch_taken_EX = b;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; prog_ctr = '0; ready_ID = 1'b0; branch_taken_EX = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [9:0] pc; logic rdy; logic br;
    logic vld; logic [9:0] pcid; logic stall; logic rden;
  } vec_t;
  vec_t vt [17];

  function automatic vec_t mk(input int pc, input int rdy, input int vld,
                              input int pcid, input int stall, input int rden);
    vec_t v;
    v.pc = 10'(pc); v.rdy = 1'(rdy); v.br = 1'b0;
    v.vld = 1'(vld); v.pcid = 10'(pcid); v.stall = 1'(stall); v.rden = 1'(rden);
    return v;
  endfunction

  task automatic run_vec(input int lo, input int hi, input string tag);
    logic [9:0]  ep;
    logic [15:0] ei;
    for (int i = lo; i <= hi; i++) begin
      drive(vt[i].pc, vt[i].rdy, vt[i].br);
      ep = vt[i].vld ? vt[i].pcid : 10'h0;
      ei = vt[i].vld ? mdata(vt[i].pcid) : 16'h0;
      chk($sformatf("%s[%0d].vld", tag, i - lo), 32'(instr_vld_ID), 32'(vt[i].vld));
      chk($sformatf("%s[%0d].pc", tag, i - lo), 32'(pc_ID), 32'(ep));
      chk($sformatf("%s[%0d].instr", tag, i - lo), 32'(instr_ID), 32'(ei));
      chk($sformatf("%s[%0d].stall", tag, i - lo), 32'(fetch_stall), 32'(vt[i].stall));
      chk($sformatf("%s[%0d].rden", tag, i - lo), 32'(imem_rd_en), 32'(vt[i].rden));
      adv();
    end
  endtask

  // Reference model: list of queued entries plus at most one outstanding read.
  typedef struct { logic [9:0] pc; logic [15:0] ins; } ent_t;
  ent_t mq[$];
  bit         infl_v;
  logic [9:0] infl_pc;

  initial begin
    int first_idx;
    int nvalid;
    logic [9:0] nxt;
    logic [9:0] pc;

    // Stream from reset with decode always ready.
    for (int c = 0; c < 6; c++)
      vt[c] = mk(c, 1, (c >= 2 - BYP) ? 1 : 0, (c >= 2 - BYP) ? c - 2 + BYP : 0, 0, 1);
    // Decode blocked: fill to four entries, then drain.
    vt[6]  = mk(0, 0, 0,   0, 0, 1);
    vt[7]  = mk(1, 0, BYP, 0, 0, 1);
    vt[8]  = mk(2, 0, 1,   0, 0, 1);
    vt[9]  = mk(3, 0, 1,   0, 0, 1);
    vt[10] = mk(4, 0, 1,   0, 1, 0);
    vt[11] = mk(4, 0, 1,   0, 1, 0);
    vt[12] = mk(4, 1, 1,   0, 1, 0);
    vt[13] = mk(4, 1, 1,   1, 1, 0);
    vt[14] = mk(4, 1, 1,   2, 0, 1);
    vt[15] = mk(5, 1, 1,   3, 0, 1);
    vt[16] = mk(6, 1, 1,   4, 0, 1);

    // Reset state.
    reset = 1'b1; prog_ctr = 10'h155; ready_ID = 1'b1; branch_taken_EX = 1'b0;
    @(negedge clk);
    chk("rst.vld", 32'(instr_vld_ID), 0);
    chk("rst.instr", 32'(instr_ID), 0);
    chk("rst.pc", 32'(pc_ID), 0);
    chk("rst.stall", 32'(fetch_stall), 0);
    chk("rst.rden", 32'(imem_rd_en), 0);
    @(posedge clk); #1;

    do_reset();
    run_vec(0, 5, "stream");

    do_reset();
    run_vec(6, 16, "fill");

    // Flush with three entries queued and one read in flight.
    do_reset();
    for (int c = 0; c < 4; c++) begin drive(10'(c), 1'b0, 1'b0); adv(); end
    drive(10'd4, 1'b0, 1'b1);
    chk("flush.pre_stall", 32'(fetch_stall), 1);
    chk("flush.pre_rden", 32'(imem_rd_en), 0);
    adv();
    drive(10'h2A0, 1'b1, 1'b0);
    chk("flush.vld", 32'(instr_vld_ID), 0);
    chk("flush.stall", 32'(fetch_stall), 0);
    chk("flush.rden", 32'(imem_rd_en), 1);
    adv();
    first_idx = -1; nvalid = 0; nxt = 10'h2A0;
    for (int k = 0; k < 6; k++) begin
      drive(10'h2A1 + 10'(k), 1'b1, 1'b0);
      if (instr_vld_ID) begin
        if (first_idx < 0) first_idx = k;
        chk($sformatf("flush.seq%0d.pc", nvalid), 32'(pc_ID), 32'(nxt));
        chk($sformatf("flush.seq%0d.instr", nvalid), 32'(instr_ID), 32'(mdata(nxt)));
        nxt++; nvalid++;
      end
      adv();
    end
    chk("flush.first_idx", 32'(first_idx), 32'(1 - BYP));
    chk("flush.nvalid", 32'(nvalid), 32'(5 + BYP));

    // Asynchronous reset in the middle of a cycle with two entries queued.
    do_reset();
    for (int c = 0; c < 3; c++) begin drive(10'(c), 1'b0, 1'b0); adv(); end
    prog_ctr = 10'd3;
    #2;
    chk("arst.pre_vld", 32'(instr_vld_ID), 1);
    reset = 1'b1;
    #1;
    chk("arst.vld", 32'(instr_vld_ID), 0);
    chk("arst.stall", 32'(fetch_stall), 0);
    chk("arst.rden", 32'(imem_rd_en), 0);
    chk("arst.pc", 32'(pc_ID), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_vec(0, 5, "restart");

    // Concurrent push and pop holding two entries.
    do_reset();
    for (int c = 0; c < 3; c++) begin drive(10'(c), 1'b0, 1'b0); adv(); end
    for (int k = 0; k < 10; k++) begin
      drive(10'(3 + k), 1'b1, 1'b0);
      chk($sformatf("pp%0d.vld", k), 32'(instr_vld_ID), 1);
      chk($sformatf("pp%0d.pc", k), 32'(pc_ID), 32'(k));
      chk($sformatf("pp%0d.stall", k), 32'(fetch_stall), 0);
      adv();
    end

    // Random traffic against the reference model.
    do_reset();
    mq.delete(); infl_v = 0; infl_pc = '0; pc = '0;
    for (int n = 0; n < 500; n++) begin
      logic r, b, e_stall, e_rden, e_vld, qe, byp, took;
      ent_t h;
      ent_t ne;
      r = ($urandom_range(0, 99) < 65);
      b = ($urandom_range(0, 99) < 6);
      drive(pc, r, b);
      qe = (mq.size() == 0);
      byp = (BYP != 0) && qe && infl_v && !b;
      e_stall = (mq.size() >= 3);
      e_rden = !e_stall && !b;
      e_vld = !qe || byp;
      h.pc = '0; h.ins = '0;
      if (!qe) h = mq[0];
      else if (byp) begin h.pc = infl_pc; h.ins = mdata(infl_pc); end
      chk($sformatf("rnd%0d.vld", n), 32'(instr_vld_ID), 32'(e_vld));
      chk($sformatf("rnd%0d.pc", n), 32'(pc_ID), 32'(h.pc));
      chk($sformatf("rnd%0d.instr", n), 32'(instr_ID), 32'(h.ins));
      chk($sformatf("rnd%0d.stall", n), 32'(fetch_stall), 32'(e_stall));
      chk($sformatf("rnd%0d.rden", n), 32'(imem_rd_en), 32'(e_rden));
      chk($sformatf("rnd%0d.addr", n), 32'(imem_addr), 32'(pc));
      if (b) begin
        mq.delete();
      end else begin
        took = e_vld && r;
        if (!qe && took) void'(mq.pop_front());
        if (infl_v && !(byp && took)) begin
          ne.pc = infl_pc; ne.ins = mdata(infl_pc);
          mq.push_back(ne);
        end
      end
      infl_v = e_rden;
      infl_pc = pc;
      if (b) pc = 10'($urandom_range(0, 1023));
      else if (!e_stall) pc = pc + 10'd1;
      adv();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_fetch_queue.md
Name: ctrl_fetch_queue

Overview:
- Instruction-fetch stage directly downstream of the program counter.
- Drives the instruction-memory address from the current PC and captures the synchronous-read data.
- Buffers {pc, instruction} pairs in a small FIFO that presents a first-word-fall-through interface to decode (ID).
- Back-pressures the PC with fetch_stall and discards all fetched and in-flight work when EX signals a taken branch.

Parameters:
- PROG_CTR_WID, 10, program counter / instruction address width.
- INSTR_WID, 16, instruction word width.
- IQ_DEPTH, 4, queue entries; must be a power of 2 and >= 2.

Ports:
- clk  in  1  core clock, all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- prog_ctr  in  PROG_CTR_WID  current PC from the program counter.
- branch_taken_EX  in  1  taken branch resolved in EX; flush request.
- imem_addr  out  PROG_CTR_WID  instruction memory read address.
- imem_rd_en  out  1  instruction memory read enable.
- imem_rdata  in  INSTR_WID  read data, valid 1 cycle after an enabled read.
- fetch_stall  out  1  hold request to the program counter.
- ready_ID  in  1  decode accepts the head entry this cycle.
- instr_vld_ID  out  1  head entry valid.
- instr_ID  out  INSTR_WID  head instruction.
- pc_ID  out  PROG_CTR_WID  PC of the head instruction.

Behaviour:
- Clock/reset: one clock, clk. reset is asynchronous and active-high. While reset is asserted: queue empty, count=0, rd/wr pointers=0, req_vld_q=0, req_pc_q=0, instr_vld_ID=0, instr_ID=0, pc_ID=0, fetch_stall=0, imem_rd_en=0.
- Read issue: imem_addr = prog_ctr (combinational). imem_rd_en = !reset && !fetch_stall && !branch_taken_EX.
- In-flight tracking: on each edge, req_vld_q <= imem_rd_en and req_pc_q <= prog_ctr.
- Push: when req_vld_q=1 and branch_taken_EX=0, {req_pc_q, imem_rdata} is written at wr_ptr.
- Pop: when instr_vld_ID && ready_ID, rd_ptr advances. Push and pop may occur in the same cycle; count is unchanged in that case.
- Head outputs: instr_vld_ID = (count != 0). instr_ID and pc_ID come from the entry at rd_ptr, and are 0 when the queue is empty.
- Stall: fetch_stall = (count >= IQ_DEPTH-1). This leaves one slot for the in-flight read, so the queue never overflows. A push when full is a design error; guard it with an assertion.
- Flush: when branch_taken_EX=1 at an edge, count, wr_ptr and rd_ptr are cleared and req_vld_q is cleared. Any pop that cycle is ignored and the pending push is dropped. Flush has priority over push and pop.
- Refetch after flush: the PC loads the branch target on the same edge, so the first read of the target issues on the following cycle.
- Latency: PC presented in cycle N, read data returns in N+1, pushed at the end of N+1, and the entry is visible on instr_vld_ID in N+2 (queue initially empty).
- Pointer wrap: pointers are log2(IQ_DEPTH) bits and wrap naturally. count is log2(IQ_DEPTH)+1 bits.
- Mid-operation reset: discards all entries and the in-flight read at once. No partial state survives.
- PC wrap: PC wrap-around is transparent to this block; it stores whatever prog_ctr supplied.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the queue is empty, req_vld_q=1 and branch_taken_EX=0, the outputs show imem_rdata and req_pc_q combinationally, with instr_vld_ID=1 in cycle N+1.
  - If ready_ID=1 that cycle, the entry is consumed and not written into the queue.
  - If ready_ID=0, it is pushed as normal.
- Not defined: fixed N+2 latency as above. No combinational path from imem_rdata to instr_ID.

Test Plan:
- Reset release, prog_ctr 0,1,2,3, imem_rdata=0x1000+addr, ready_ID=1 -> instr_vld_ID first high in cycle 2 with instr_ID=0x1000, pc_ID=0; then one instruction per cycle in order.
- ready_ID=0 held with a streaming PC -> fetch_stall high once count=3. Exactly 4 entries held (pc 0..3), no overwrite. Releasing ready_ID drains 0,1,2,3 in order, and fetch_stall drops when count<3.
- Queue holding 3 entries plus an in-flight read, pulse branch_taken_EX while prog_ctr steps to 0x2A0 -> the cycle after the flush instr_vld_ID=0. The next valid output is pc_ID=0x2A0; no stale pc 0..4 appears.
- Assert reset asynchronously mid-cycle with 2 entries queued -> instr_vld_ID=0, fetch_stall=0 and imem_rd_en=0 before the next edge. After release, fetch restarts from PC 0.
- Simultaneous push and pop at count=2 for 10 cycles -> count stays 2, order is preserved and fetch_stall remains 0.
- With FETCH_BYPASS_EN, empty queue, ready_ID=1 -> instr_vld_ID high in cycle N+1 with instr_ID=imem_rdata. Without the macro, the same stimulus gives N+2.
